vector_store_unit: RTL
======================

# vector_store_unit

Drains 128-bit result vectors from the vectorial ALU datapath and writes them to a narrower word-addressed data memory as consecutive words, one store job at a time. It is the consumer end of the vector result path: the ALU result register presents vectors with a valid/ready handshake, and this block serialises each vector into N/W memory writes. Alpha-composited pixel blocks leave the vector core through this block.

## Interface
- N, 128, vector width in bits; must be an integer multiple of W
- W, 32, memory data word width in bits
- AW, 16, memory word-address width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that launches a store job; ignored while busy=1
- base_addr  input  AW  first word address of the job; sampled on accepted start
- count  input  AW  number of vectors in the job; sampled on accepted start
- vec_valid  input  1  vec_data holds a vector
- vec_data  input  N  result vector
- vec_ready  output  1  block accepts a vector this cycle
- mem_we  output  1  write request
- mem_addr  output  AW  write word address
- mem_wdata  output  W  write data
- mem_ready  input  1  memory accepts the write this cycle
- busy  output  1  job in progress
- done  output  1  one-cycle pulse, job complete

## Operation
- WORDS = N/W (4 at defaults). Word k of a vector is vec_data[k*W +: W]; word 0 goes to the lowest address.
- Two-entry vector FIFO. A vector is accepted when vec_valid && vec_ready. vec_ready = busy && FIFO not full && vectors accepted < count. It is registered and carries no combinational path from vec_valid or mem_ready.
- FSM states:
  - IDLE: on start, latch base_addr and count. If count==0, go to FINISH; otherwise go to RUN and set busy.
  - RUN: when the FIFO is non-empty, drive the head word; advance the word index on each mem_we && mem_ready. After word WORDS-1 is accepted, pop the FIFO. When the last word of vector count-1 is accepted, go to FINISH.
  - FINISH: pulse done for one cycle, clear busy, go to IDLE.
- mem_addr starts at base_addr and increments by 1 per accepted word, wrapping modulo 2^AW (0xFFFF+1 = 0x0000).
- While mem_we=1 and mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Vectors presented while not busy, or beyond count, are not accepted (vec_ready=0).
- Reset, including mid-job: asynchronously returns to IDLE, flushes the FIFO, and clears all counters. No further writes are issued.

## Timing
- Reset values: vec_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
- start at edge t: busy=1 and vec_ready=1 from cycle t+1.
- Vector accepted at edge t with an empty FIFO and an idle writer: mem_we=1 with word 0 from cycle t+1.
- With mem_ready held at 1, one word per cycle, so one vector per WORDS cycles. Enqueue and dequeue in the same cycle are allowed; FIFO occupancy is unchanged.
- Last word accepted at edge t: done=1 during cycle t+1, and busy=0 from cycle t+2.
- count==0: start at t gives done during cycle t+2, with no mem_we.
- Throughput: back-to-back vectors stream with no bubble between vectors when the FIFO is non-empty.

## Configuration
- VSTORE_BYTE_SWAP_EN defined: each W-bit word is byte-reversed before it drives mem_wdata (big-endian store).
- Without it: mem_wdata is the word slice unchanged.
- Addresses, ordering and timing are identical in both builds.

## Test plan
- Basic store: start with base_addr=0x0100 and count=1; vector 0x44444444_33333333_22222222_11111111; mem_ready=1. Expect writes 0x11111111@0x0100, 0x22222222@0x0101, 0x33333333@0x0102, 0x44444444@0x0103 on consecutive cycles, then one done pulse.
- Streaming: count=3, vec_valid always 1, mem_ready=1. Expect 12 consecutive write cycles at 0x0000–0x000B, exactly 3 vectors accepted, and vec_ready=0 after the third.
- Backpressure: mem_ready toggles 0/1 each cycle. Expect outputs stable while stalled, no duplicated or skipped words, the FIFO filling to 2, and vec_ready=0 while full.
- Edge cases: base_addr=0xFFFE with count=1 writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001. count=0 pulses done with no writes. start while busy is ignored.
- Reset mid-job: assert rst low after 2 words. Expect all outputs at reset values immediately and no writes after release. A new start then completes normally.
- Byte swap: build with VSTORE_BYTE_SWAP_EN and store word 0x11223344. Expect mem_wdata=0x44332211.

Source files
------------

// File: rtl/vector_store_unit.sv
// vector_store_unit: drains N-bit result vectors into a W-bit word-addressed
// memory, one store job at a time. Each accepted vector is queued in a
// two-entry FIFO and written out as N/W consecutive words, word 0 first.
// Optional feature macro: VSTORE_BYTE_SWAP_EN byte-reverses every W-bit word
// before it drives mem_wdata (big-endian store). Without it, words go out unchanged.
//
// Handshakes: a vector transfers on a rising edge where vec_valid && vec_ready;
// a memory word transfers on a rising edge where mem_we && mem_ready. Once
// raised, mem_we, mem_addr and mem_wdata stay stable until mem_ready is seen.
// vec_ready is a register, so it never depends combinationally on vec_valid or mem_ready.
module vector_store_unit #(
  parameter int N  = 128,
  parameter int W  = 32,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count,
  input  logic          vec_valid,
  input  logic [N-1:0]  vec_data,
  output logic          vec_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  localparam int WORDS = N / W;
  localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic            vec_ready_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   count_q;
  logic [AW-1:0]   acc_cnt_q;   // vectors accepted in this job
  logic [AW-1:0]   wr_cnt_q;    // vectors fully written in this job
  logic [WIDX-1:0] word_idx_q;  // word of the head vector being written
  logic [N-1:0]    fifo_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      fifo_cnt_q;

  logic            push;
  logic            wr_fire;
  logic            last_word;
  logic            pop;
  logic            job_last;
  logic [1:0]      fifo_cnt_d;
  logic [AW-1:0]   acc_cnt_d;
  logic [W-1:0]    head_word;
  logic [W-1:0]    word_out;

`ifdef VSTORE_BYTE_SWAP_EN
  function automatic logic [W-1:0] byte_swap(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W / 8; b++) begin
      r[8*b +: 8] = w[W-8-8*b +: 8];
    end
    return r;
  endfunction
  assign word_out = byte_swap(head_word);
`else
  assign word_out = head_word;
`endif

  // Handshake events and next-state helpers shared by the FSM and the FIFO.
  always_comb begin
    push       = vec_valid && vec_ready_q;
    wr_fire    = mem_we && mem_ready;
    last_word  = (word_idx_q == WIDX'(WORDS - 1));
    pop        = wr_fire && last_word;
    job_last   = pop && (wr_cnt_q == count_q - 1'b1);
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
    acc_cnt_d  = acc_cnt_q + AW'(push);
    head_word  = fifo_q[rd_ptr_q][int'(word_idx_q)*W +: W];
  end

  assign mem_we    = (state_q == S_RUN) && (fifo_cnt_q != 2'd0);
  assign mem_wdata = mem_we ? word_out : '0;
  assign mem_addr  = addr_q;
  assign vec_ready = vec_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

  // FIFO storage carries no reset; occupancy and pointers live in the FSM block.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= vec_data;
  end

  // Job FSM, FIFO pointers, word/vector counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_ready_q <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      word_idx_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      fifo_cnt_q <= fifo_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (wr_fire) begin
        addr_q     <= addr_q + 1'b1;
        word_idx_q <= last_word ? '0 : word_idx_q + 1'b1;
        if (last_word) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          vec_ready_q <= 1'b0;
          if (start) begin
            addr_q     <= base_addr;
            count_q    <= count;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            word_idx_q <= '0;
            if (count == '0) begin
              state_q <= S_FINISH;
            end else begin
              state_q     <= S_RUN;
              busy_q      <= 1'b1;
              vec_ready_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          vec_ready_q <= (fifo_cnt_d != 2'd2) && (acc_cnt_d < count_q) && !job_last;
          if (job_last) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          // A zero-count job reaches here with busy low and pulses done one
          // cycle later; a normal job already pulsed done on its last word.
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          vec_ready_q <= 1'b0;
          done_q      <= !busy_q;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          vec_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
